// File: rtl/spike_out_router_buffer.sv
// Spike output router buffer: FIFO of spike packets, one-hop routing by signed dx/dy, registered output stage.
// Optional feature macro: SPIKE_DROP_COUNT_EN (enables the saturating dropped-packet counter).
module spike_out_router_buffer #(
  parameter int DEPTH        = 4,
  parameter int PACKET_WIDTH = 30
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [PACKET_WIDTH-1:0] packet_in,
  input  logic                    packet_in_valid,
  output logic                    local_buffers_full,
  output logic [PACKET_WIDTH-1:0] packet_out,
  output logic [4:0]              out_valid,
  input  logic [4:0]              out_ready,
  output logic [15:0]             drop_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  localparam logic [4:0] DIR_EAST  = 5'b00001;
  localparam logic [4:0] DIR_WEST  = 5'b00010;
  localparam logic [4:0] DIR_NORTH = 5'b00100;
  localparam logic [4:0] DIR_SOUTH = 5'b01000;
  localparam logic [4:0] DIR_LOCAL = 5'b10000;

  logic [PACKET_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]           wr_ptr;
  logic [AW-1:0]           rd_ptr;
  logic [CW-1:0]           count;

  logic                    stage_free;
  logic                    push;
  logic                    pop;
  logic [PACKET_WIDTH-1:0] head;
  logic [8:0]              head_dx;
  logic [8:0]              head_dy;
  logic [4:0]              route_dir;
  logic [PACKET_WIDTH-1:0] route_pkt;

  // Handshake: a packet leaves the output stage on a rising edge where its one-hot
  // out_valid bit and the matching out_ready bit are both high; out_valid never waits on ready.
  assign stage_free         = (out_valid == 5'b00000) || ((out_valid & out_ready) != 5'b00000);
  assign local_buffers_full = (count == FULL_COUNT);
  assign push               = packet_in_valid && !local_buffers_full;
  assign pop                = (count != '0) && stage_free;

  assign head    = mem[rd_ptr];
  assign head_dx = head[29:21];
  assign head_dy = head[20:12];

  // Offsets always step toward zero, so -256 becomes -255 and +255 becomes +254 without overflow.
  always_comb begin
    route_dir = DIR_LOCAL;
    route_pkt = head;
    if (head_dx[8]) begin
      route_dir        = DIR_WEST;
      route_pkt[29:21] = head_dx + 9'd1;
    end else if (head_dx != 9'd0) begin
      route_dir        = DIR_EAST;
      route_pkt[29:21] = head_dx - 9'd1;
    end else if (head_dy[8]) begin
      route_dir        = DIR_SOUTH;
      route_pkt[20:12] = head_dy + 9'd1;
    end else if (head_dy != 9'd0) begin
      route_dir        = DIR_NORTH;
      route_pkt[20:12] = head_dy - 9'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= packet_in;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (push && !pop) begin
        count <= count + CW'(1);
      end else if (pop && !push) begin
        count <= count - CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid  <= '0;
      packet_out <= '0;
    end else if (pop) begin
      out_valid  <= route_dir;
      packet_out <= route_pkt;
    end else if (stage_free) begin
      out_valid  <= '0;
    end
  end

`ifdef SPIKE_DROP_COUNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drop_count <= '0;
    end else if (packet_in_valid && local_buffers_full && (drop_count != 16'hFFFF)) begin
      drop_count <= drop_count + 16'd1;
    end
  end
`else
  assign drop_count = 16'd0;
`endif

endmodule

// File: tb/tb_spike_out_router_buffer.sv
// Directed testbench for spike_out_router_buffer: inputs driven and outputs sampled on the falling edge.
module tb_spike_out_router_buffer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [29:0] packet_in = '0;
  logic        packet_in_valid = 1'b0;
  logic [4:0]  out_ready = '0;
  logic        local_buffers_full;
  logic [29:0] packet_out;
  logic [4:0]  out_valid;
  logic [15:0] drop_count;

  int n_cmp = 0;
  int n_err = 0;
  logic [29:0] exp_q[$];

`ifdef SPIKE_DROP_COUNT_EN
  localparam bit DROP_EN = 1'b1;
`else
  localparam bit DROP_EN = 1'b0;
`endif

  spike_out_router_buffer #(.DEPTH(4), .PACKET_WIDTH(30)) dut (
    .clk                (clk),
    .reset              (reset),
    .packet_in          (packet_in),
    .packet_in_valid    (packet_in_valid),
    .local_buffers_full (local_buffers_full),
    .packet_out         (packet_out),
    .out_valid          (out_valid),
    .out_ready          (out_ready),
    .drop_count         (drop_count)
  );

  always #5 clk = ~clk;

  function automatic logic [29:0] pkt(input logic [8:0] dx, input logic [8:0] dy,
                                      input logic [7:0] ax, input logic [3:0] tk);
    return {dx, dy, ax, tk};
  endfunction

  task automatic test_reset;
    repeat (2) @(negedge clk);
    n_cmp++; if (out_valid !== 5'b00000) begin n_err++; $display("FAIL rst_valid: got %b expected 00000", out_valid); end
    n_cmp++; if (packet_out !== 30'd0) begin n_err++; $display("FAIL rst_packet: got %h expected 0", packet_out); end
    n_cmp++; if (local_buffers_full !== 1'b0) begin n_err++; $display("FAIL rst_full: got %b expected 0", local_buffers_full); end
    n_cmp++; if (drop_count !== 16'd0) begin n_err++; $display("FAIL rst_drop: got %0d expected 0", drop_count); end
    reset = 1'b0;
  endtask

  task automatic test_routing;
    logic [29:0] in_p  [6];
    logic [29:0] exp_p [6];
    logic [4:0]  exp_v [6];
    in_p[0] = pkt(9'd3, 9'd0, 8'h2A, 4'h5);       exp_p[0] = pkt(9'd2, 9'd0, 8'h2A, 4'h5);       exp_v[0] = 5'b00001;
    in_p[1] = pkt(9'h100, 9'd0, 8'h77, 4'h3);     exp_p[1] = pkt(9'h101, 9'd0, 8'h77, 4'h3);     exp_v[1] = 5'b00010;
    in_p[2] = pkt(9'h1FD, 9'd7, 8'h10, 4'h1);     exp_p[2] = pkt(9'h1FE, 9'd7, 8'h10, 4'h1);     exp_v[2] = 5'b00010;
    in_p[3] = pkt(9'd0, 9'd5, 8'hC3, 4'hF);       exp_p[3] = pkt(9'd0, 9'd4, 8'hC3, 4'hF);       exp_v[3] = 5'b00100;
    in_p[4] = pkt(9'd0, 9'h100, 8'h01, 4'h0);     exp_p[4] = pkt(9'd0, 9'h101, 8'h01, 4'h0);     exp_v[4] = 5'b01000;
    in_p[5] = pkt(9'h0FF, 9'h1FF, 8'h55, 4'hA);   exp_p[5] = pkt(9'h0FE, 9'h1FF, 8'h55, 4'hA);   exp_v[5] = 5'b00001;
    out_ready = 5'b11111;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      packet_in = in_p[i];
      packet_in_valid = 1'b1;
      @(negedge clk);
      packet_in_valid = 1'b0;
      n_cmp++; if (out_valid !== 5'b00000) begin n_err++; $display("FAIL route%0d_latency: got %b expected 00000", i, out_valid); end
      @(negedge clk);
      n_cmp++; if (out_valid !== exp_v[i]) begin n_err++; $display("FAIL route%0d_valid: got %b expected %b", i, out_valid, exp_v[i]); end
      n_cmp++; if (packet_out !== exp_p[i]) begin n_err++; $display("FAIL route%0d_packet: got %h expected %h", i, packet_out, exp_p[i]); end
    end
  endtask

  task automatic test_south_local;
    @(negedge clk);
    out_ready = 5'b11111;
    packet_in = pkt(9'd0, 9'h1FF, 8'h11, 4'h1);
    packet_in_valid = 1'b1;
    @(negedge clk);
    packet_in = pkt(9'd0, 9'd0, 8'h22, 4'h2);
    @(negedge clk);
    packet_in_valid = 1'b0;
    n_cmp++; if (out_valid !== 5'b01000) begin n_err++; $display("FAIL south_valid: got %b expected 01000", out_valid); end
    n_cmp++; if (packet_out !== pkt(9'd0, 9'd0, 8'h11, 4'h1)) begin n_err++; $display("FAIL south_packet: got %h expected %h", packet_out, pkt(9'd0, 9'd0, 8'h11, 4'h1)); end
    @(negedge clk);
    n_cmp++; if (out_valid !== 5'b10000) begin n_err++; $display("FAIL local_valid: got %b expected 10000", out_valid); end
    n_cmp++; if (packet_out !== pkt(9'd0, 9'd0, 8'h22, 4'h2)) begin n_err++; $display("FAIL local_packet: got %h expected %h", packet_out, pkt(9'd0, 9'd0, 8'h22, 4'h2)); end
    @(negedge clk);
    n_cmp++; if (out_valid !== 5'b00000) begin n_err++; $display("FAIL sl_drained: got %b expected 00000", out_valid); end
  endtask

  task automatic test_backpressure;
    @(negedge clk);
    out_ready = 5'b00000;
    for (int i = 0; i < 6; i++) begin
      packet_in = pkt(9'd1, 9'd0, 8'(8'h40 + i), 4'(i));
      packet_in_valid = 1'b1;
      if (i == 5) begin
        n_cmp++; if (local_buffers_full !== 1'b1) begin n_err++; $display("FAIL bp_full_before6: got %b expected 1", local_buffers_full); end
      end
      @(negedge clk);
    end
    packet_in_valid = 1'b0;
    n_cmp++; if (local_buffers_full !== 1'b1) begin n_err++; $display("FAIL bp_full: got %b expected 1", local_buffers_full); end
    n_cmp++; if (out_valid !== 5'b00001) begin n_err++; $display("FAIL bp_valid: got %b expected 00001", out_valid); end
    n_cmp++; if (drop_count !== (DROP_EN ? 16'd1 : 16'd0)) begin n_err++; $display("FAIL bp_drop: got %0d expected %0d", drop_count, DROP_EN ? 1 : 0); end
    out_ready = 5'b11110;
    repeat (2) @(negedge clk);
    n_cmp++; if (out_valid !== 5'b00001) begin n_err++; $display("FAIL bp_hold_valid: got %b expected 00001", out_valid); end
    n_cmp++; if (packet_out !== pkt(9'd0, 9'd0, 8'h40, 4'h0)) begin n_err++; $display("FAIL bp_hold_packet: got %h expected %h", packet_out, pkt(9'd0, 9'd0, 8'h40, 4'h0)); end
    out_ready = 5'b00001;
    for (int k = 0; k < 5; k++) begin
      n_cmp++; if (out_valid !== 5'b00001) begin n_err++; $display("FAIL bp_out%0d_valid: got %b expected 00001", k, out_valid); end
      n_cmp++; if (packet_out !== pkt(9'd0, 9'd0, 8'(8'h40 + k), 4'(k))) begin n_err++; $display("FAIL bp_out%0d_packet: got %h expected %h", k, packet_out, pkt(9'd0, 9'd0, 8'(8'h40 + k), 4'(k))); end
      @(negedge clk);
    end
    n_cmp++; if (out_valid !== 5'b00000) begin n_err++; $display("FAIL bp_sixth_dropped: got %b expected 00000", out_valid); end
    n_cmp++; if (local_buffers_full !== 1'b0) begin n_err++; $display("FAIL bp_empty_full: got %b expected 0", local_buffers_full); end
  endtask

  task automatic test_back_to_back;
    exp_q.delete();
    out_ready = 5'b00000;
    for (int i = 0; i < 5; i++) begin
      packet_in = pkt(9'd1, 9'd0, 8'(8'h80 + i), 4'(i));
      packet_in_valid = 1'b1;
      exp_q.push_back(pkt(9'd0, 9'd0, 8'(8'h80 + i), 4'(i)));
      @(negedge clk);
    end
    out_ready = 5'b00001;
    // Full is seen only on the first streaming cycle; afterwards push and pop balance at DEPTH-1.
    for (int j = 0; j < 8; j++) begin
      packet_in = pkt(9'd1, 9'd0, 8'(8'hC0 + j), 4'(j));
      packet_in_valid = 1'b1;
      n_cmp++; if (local_buffers_full !== (j == 0)) begin n_err++; $display("FAIL b2b%0d_full: got %b expected %b", j, local_buffers_full, j == 0); end
      n_cmp++; if (out_valid !== 5'b00001 || packet_out !== exp_q[0]) begin n_err++; $display("FAIL b2b%0d_out: got %b/%h expected 00001/%h", j, out_valid, packet_out, exp_q[0]); end
      void'(exp_q.pop_front());
      if (j != 0) exp_q.push_back(pkt(9'd0, 9'd0, 8'(8'hC0 + j), 4'(j)));
      @(negedge clk);
    end
    packet_in_valid = 1'b0;
    for (int c = 0; c < 16; c++) begin
      if (exp_q.size() == 0) break;
      n_cmp++; if (out_valid !== 5'b00001 || packet_out !== exp_q[0]) begin n_err++; $display("FAIL b2b_drain_out: got %b/%h expected 00001/%h", out_valid, packet_out, exp_q[0]); end
      void'(exp_q.pop_front());
      @(negedge clk);
    end
    n_cmp++; if (out_valid !== 5'b00000) begin n_err++; $display("FAIL b2b_drained: got %b expected 00000", out_valid); end
    n_cmp++; if (drop_count !== (DROP_EN ? 16'd2 : 16'd0)) begin n_err++; $display("FAIL b2b_drop: got %0d expected %0d", drop_count, DROP_EN ? 2 : 0); end
  endtask

  task automatic test_reset_midstream;
    out_ready = 5'b00000;
    for (int i = 0; i < 4; i++) begin
      packet_in = pkt(9'd1, 9'd0, 8'(8'hA0 + i), 4'(i));
      packet_in_valid = 1'b1;
      @(negedge clk);
    end
    packet_in_valid = 1'b0;
    n_cmp++; if (out_valid !== 5'b00001) begin n_err++; $display("FAIL mid_pre_valid: got %b expected 00001", out_valid); end
    reset = 1'b1;
    #1;
    n_cmp++; if (out_valid !== 5'b00000) begin n_err++; $display("FAIL mid_async_valid: got %b expected 00000", out_valid); end
    @(negedge clk);
    n_cmp++; if (packet_out !== 30'd0) begin n_err++; $display("FAIL mid_packet: got %h expected 0", packet_out); end
    n_cmp++; if (local_buffers_full !== 1'b0) begin n_err++; $display("FAIL mid_full: got %b expected 0", local_buffers_full); end
    n_cmp++; if (drop_count !== 16'd0) begin n_err++; $display("FAIL mid_drop: got %0d expected 0", drop_count); end
    reset = 1'b0;
    out_ready = 5'b11111;
    repeat (3) @(negedge clk);
    n_cmp++; if (out_valid !== 5'b00000) begin n_err++; $display("FAIL mid_flushed: got %b expected 00000", out_valid); end
  endtask

  initial begin
    test_reset();
    test_routing();
    test_south_local();
    test_backpressure();
    test_back_to_back();
    test_reset_midstream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
